pipeline_fwd: RTL and testbench
===============================

// Module: pipeline_fwd
// PURPOSE
//  Parametrised 3-stage (ID/EX/WB) integer pipeline with a per-cycle instruction stream.
//  Successor to the fixed 32-bit pipeline: adds width/regfile parameters, SUB/MOV ops and an
//  OutValid qualifier. Optional EX->ID forwarding removes the distance-1 RAW hazard.
//  Sits between the instruction source (bench/fetch) and result observers.
// PARAMETERS
//  DATA_W      32  datapath and register width (>=16)
//  REG_AW      5   regfile address bits (<=5); NUM_REGS = 2**REG_AW; uses low REG_AW bits of fields
//  IMM_SIGNED  0   0: zero-extend imm16 to DATA_W; 1: sign-extend
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  InstrIn      in   32      instruction, sampled every rising edge
//  WriteEnable  in   1       regfile write gate, applied in the WB stage (not at issue)
//  Out          out  DATA_W  WB-stage ALU result
//  OutValid     out  1       Out holds a retired valid (non-NOP) instruction result
// BEHAVIOUR
//  Encoding: [31:26] op, [25:21] rd, [20:16] rs, [15:11] rt (R), [15:0] imm (I).
//  R ops (B = R[rt]): 010000 MOV, 010001 NOT, 010010 ADD, 010011 SUB, 010100 OR, 010101 AND, 010110 SLT
//  I ops (B = ext(imm)): 011000 MOV, 011001 NOT, 011010 ADD, 011011 SUB, 011100 OR, 011101 AND, 011110 SLT
//  NOT = ~R[rs]; MOV = B; ADD/SUB mod 2**DATA_W, carry dropped;
//  SLT = signed R[rs] < B ? 1 : 0 (zero-filled).
//  Any other opcode (incl. 0) = NOP: no write, OutValid=0 when it reaches WB.
//  Stages: edge k loads InstrIn into IR;
//   edge k+1 loads op, rd, operands (regfile read, comb.) into EXR;
//   edge k+2 loads ALU result into WBR and writes R[rd] if valid && WriteEnable.
//  Latency: Out/OutValid reflect instruction captured at edge k after edge k+2. Throughput 1/cycle.
//  WriteEnable sampled at edge k+2 (WB); WriteEnable=0 still retires: Out/OutValid update, R unchanged.
//  Regfile: plain storage, no r0 hardwiring; NUM_REGS x DATA_W.
//  Distance>=2 dependencies always see the new value: write at k+2 precedes read for EXR load at k+3.
//  Distance-1 dependency: the consumer's EXR load coincides with the producer's write edge.
//  Reset (rst=1 at an edge): IR, EXR, WBR cleared to NOP/0; all registers 0; Out=0; OutValid=0.
//  Reset mid-stream: in-flight instructions dropped, no regfile write at that edge.
//  The first instruction after release is the one sampled on the first edge with rst=0.
// CONFIGURATION
//  PIPE_FWD_EN defined:
//   - Applies when the EX instruction is valid, writes (WriteEnable high that cycle), and
//     rd equals the ID rs/rt being read.
//   - The EXR operand takes the EX ALU result instead of the regfile value; rs and rt muxed independently.
//  PIPE_FWD_EN undefined:
//   - No bypass; distance-1 consumer reads the stale regfile value.
//   - Software must insert one NOP.
// TESTING
//  1 rst=1 for 5 cycles, InstrIn=0 -> Out=0, OutValid=0; then NOPs keep OutValid=0.
//  2 Issue I-ADD r1,r1,000A from reset -> 2 edges later Out=0000000A, OutValid=1; r1=0000000A.
//  3 I-ADD r2,r2,FFF8 then next cycle R-ADD r8,r1,r2 -> Out(r8)=00010002 with PIPE_FWD_EN,
//    0000000A without; with one NOP between, 00010002 in both builds.
//  4 WriteEnable=0 during WB of I-MOV r3,#0005 -> Out=00000005, OutValid=1.
//    Later R-MOV r4,r3 -> Out=00000000.
//  5 R-NOT r7,r1 -> FFFFFFF5; R-SLT r15,r7,r1 -> 00000001;
//    R-SLT r15,r7,r7 -> 00000000; I-SLT r6,r6(0),#FFF8 -> 00000001 (IMM_SIGNED=0).
//  6 rst pulsed 1 cycle with two writes in flight -> neither target changes;
//    Out=0, OutValid=0 next cycle; stream resumes with correct latency.

Source files
------------

// File: rtl/pipeline_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_fwd
//  Purpose  : Parametrised 3-stage (ID/EX/WB) integer pipeline taking one
//             instruction per cycle. The regfile is written in WB and gated by
//             WriteEnable. Out/OutValid show the retiring result.
//  Options  : PIPE_FWD_EN - when defined, the EX result is bypassed into the
//             ID operand read. This removes the distance-1 RAW hazard.
//  Revision : 1.0 - initial parametrised release (SUB/MOV, OutValid)
// ============================================================================
module pipeline_fwd #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter bit IMM_SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrIn,
    input  logic              WriteEnable,
    output logic [DATA_W-1:0] Out,
    output logic              OutValid
);

    localparam int         c_NUM_REGS = 2**REG_AW;
    localparam logic [2:0] c_FN_MOV   = 3'd0;
    localparam logic [2:0] c_FN_NOT   = 3'd1;
    localparam logic [2:0] c_FN_ADD   = 3'd2;
    localparam logic [2:0] c_FN_SUB   = 3'd3;
    localparam logic [2:0] c_FN_OR    = 3'd4;
    localparam logic [2:0] c_FN_AND   = 3'd5;
    localparam logic [2:0] c_FN_SLT   = 3'd6;

    // Pipeline state
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_regs [c_NUM_REGS];
    logic              r_ex_valid;
    logic [2:0]        r_ex_fn;
    logic [REG_AW-1:0] r_ex_rd;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [DATA_W-1:0] r_wb_out;
    logic              r_wb_valid;

    // ID-stage decode
    logic [5:0]        w_op;
    logic              w_id_valid;
    logic              w_id_imm;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;
    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_opb;
    logic [DATA_W-1:0] w_ex_result;
    logic              w_wb_write;

    // Opcodes 01x000..01x110 are live; bit 3 selects the immediate form. All else is NOP.
    assign w_op       = r_ir[31:26];
    assign w_id_valid = (w_op[5:4] == 2'b01) && (w_op[2:0] != 3'b111);
    assign w_id_imm   = w_op[3];
    assign w_rd       = r_ir[21 +: REG_AW];
    assign w_rs       = r_ir[16 +: REG_AW];
    assign w_rt       = r_ir[11 +: REG_AW];

    generate
        if (IMM_SIGNED) begin : g_imm_sext
            assign w_imm_ext = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
        end else begin : g_imm_zext
            assign w_imm_ext = {{(DATA_W-16){1'b0}}, r_ir[15:0]};
        end
    endgenerate

    assign w_rf_a     = r_regs[w_rs];
    assign w_rf_b     = r_regs[w_rt];
    assign w_wb_write = r_ex_valid && WriteEnable;

`ifdef PIPE_FWD_EN
    // The EX result lands in the regfile on the same edge that loads EXR, so bypass it.
    assign w_opa    = (w_wb_write && (r_ex_rd == w_rs)) ? w_ex_result : w_rf_a;
    assign w_rt_val = (w_wb_write && (r_ex_rd == w_rt)) ? w_ex_result : w_rf_b;
`else
    assign w_opa    = w_rf_a;
    assign w_rt_val = w_rf_b;
`endif

    assign w_opb = w_id_imm ? w_imm_ext : w_rt_val;

    // IF->ID: capture the incoming instruction every cycle
    always_ff @(posedge clk) begin
        if (rst) r_ir <= '0;
        else     r_ir <= InstrIn;
    end

    // ID->EX: latch the decoded function, destination and operands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_fn    <= '0;
            r_ex_rd    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
        end else begin
            r_ex_valid <= w_id_valid;
            r_ex_fn    <= w_op[2:0];
            r_ex_rd    <= w_rd;
            r_ex_a     <= w_opa;
            r_ex_b     <= w_opb;
        end
    end

    // EX: ALU, with the carry dropped and SLT as a signed compare
    always_comb begin
        w_ex_result = '0;
        case (r_ex_fn)
            c_FN_MOV: w_ex_result = r_ex_b;
            c_FN_NOT: w_ex_result = ~r_ex_a;
            c_FN_ADD: w_ex_result = r_ex_a + r_ex_b;
            c_FN_SUB: w_ex_result = r_ex_a - r_ex_b;
            c_FN_OR:  w_ex_result = r_ex_a | r_ex_b;
            c_FN_AND: w_ex_result = r_ex_a & r_ex_b;
            c_FN_SLT: w_ex_result = ($signed(r_ex_a) < $signed(r_ex_b)) ?
                                    {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            default:  w_ex_result = '0;
        endcase
    end

    // EX->WB: retire the result. A NOP shows zero with OutValid low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_out   <= '0;
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_out   <= r_ex_valid ? w_ex_result : '0;
            r_wb_valid <= r_ex_valid;
        end
    end

    // Regfile: cleared on reset and written at WB when WriteEnable is high
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_write) begin
            r_regs[r_ex_rd] <= w_ex_result;
        end
    end

    assign Out      = r_wb_out;
    assign OutValid = r_wb_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_fwd
//  Purpose  : Self-checking bench for pipeline_fwd. It runs directed scenarios
//             and then a random stream. Both are checked against an
//             architectural model that holds the regfile and in-flight records.
//  Revision : 1.0 - initial bench
// ============================================================================
module tb_pipeline_fwd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] InstrIn = '0;
    logic        WriteEnable = 1'b0;
    logic [31:0] Out;
    logic        OutValid;

    int n_pass  = 0;
    int n_total = 0;

    pipeline_fwd #(
        .DATA_W     (32),
        .REG_AW     (5),
        .IMM_SIGNED (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .InstrIn     (InstrIn),
        .WriteEnable (WriteEnable),
        .Out         (Out),
        .OutValid    (OutValid)
    );

    always #5 clk = ~clk;

    // Architectural model: the register file, the instruction waiting for its
    // operand read, and the instruction holding a snapshot of its operands.
    logic [31:0] m_regs [32];
    logic [31:0] m_wait_ins = '0;
    logic [31:0] m_exec_ins = '0;
    logic [31:0] m_exec_a   = '0;
    logic [31:0] m_exec_b   = '0;
    logic [31:0] exp_out    = '0;
    logic        exp_valid  = 1'b0;

    function automatic logic [31:0] r_ins(input int fn, input int rd, input int rs, input int rt);
        return {3'b010, 3'(fn), 5'(rd), 5'(rs), 5'(rt), 11'd0};
    endfunction

    function automatic logic [31:0] i_ins(input int fn, input int rd, input int rs, input logic [15:0] imm);
        return {3'b011, 3'(fn), 5'(rd), 5'(rs), imm};
    endfunction

    function automatic bit is_live(input logic [31:0] ins);
        return (ins[31:30] == 2'b01) && (ins[28:26] != 3'b111);
    endfunction

    function automatic logic [31:0] semantics(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        case (ins[28:26])
            3'd0: return b;
            3'd1: return ~a;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return a | b;
            3'd5: return a & b;
            3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of architectural behaviour.
    task automatic model_edge(input logic r, input logic we, input logic [31:0] ins);
        logic [31:0] res;
        logic [31:0] oa;
        logic [31:0] ob;
        logic        imm;
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_wait_ins = '0;
            m_exec_ins = '0;
            exp_out    = '0;
            exp_valid  = 1'b0;
        end else begin
            res       = semantics(m_exec_ins, m_exec_a, m_exec_b);
            exp_valid = is_live(m_exec_ins);
            if (exp_valid) exp_out = res;
            imm = m_wait_ins[29];
            // Without a bypass the reader sees the regfile as it was before this edge's write.
            oa = m_regs[m_wait_ins[20:16]];
            ob = imm ? {16'h0, m_wait_ins[15:0]} : m_regs[m_wait_ins[15:11]];
            if (exp_valid && we) m_regs[m_exec_ins[25:21]] = res;
`ifdef PIPE_FWD_EN
            oa = m_regs[m_wait_ins[20:16]];
            if (!imm) ob = m_regs[m_wait_ins[15:11]];
`endif
            m_exec_ins = m_wait_ins;
            m_exec_a   = oa;
            m_exec_b   = ob;
            m_wait_ins = ins;
        end
    endtask

    // Drive one cycle, let the edge happen, then step the model and settle.
    task automatic step(input logic [31:0] ins, input logic we, input logic r);
        InstrIn     = ins;
        WriteEnable = we;
        rst         = r;
        @(posedge clk);
        model_edge(r, we, ins);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 5; i++) begin
            step(32'h0, 1'b0, 1'b1);
            n_total++;
            if (Out !== 32'h0 || OutValid !== 1'b0)
                $display("FAIL reset_hold[%0d]: Out=%h OutValid=%b expected 00000000/0", i, Out, OutValid);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            step(32'h0, 1'b1, 1'b0);
            n_total++;
            if (OutValid !== 1'b0)
                $display("FAIL reset_nop[%0d]: OutValid=%b expected 0", i, OutValid);
            else n_pass++;
        end
    endtask

    task automatic test_add_imm;
        step(i_ins(2, 1, 1, 16'h000A), 1'b1, 1'b0);
        n_total++;
        if (OutValid !== 1'b0) $display("FAIL add_imm_lat1: OutValid=%b expected 0", OutValid);
        else n_pass++;
        step(32'h0, 1'b1, 1'b0);
        n_total++;
        if (OutValid !== 1'b0) $display("FAIL add_imm_lat2: OutValid=%b expected 0", OutValid);
        else n_pass++;
        step(32'h0, 1'b1, 1'b0);
        n_total++;
        if (Out !== 32'h0000000A || OutValid !== 1'b1)
            $display("FAIL add_imm_out: Out=%h OutValid=%b expected 0000000a/1", Out, OutValid);
        else n_pass++;
    endtask

    task automatic test_forwarding;
        logic [31:0] want_d1;
`ifdef PIPE_FWD_EN
        want_d1 = 32'h00010002;
`else
        want_d1 = 32'h0000000A;
`endif
        step(i_ins(2, 2, 2, 16'hFFF8), 1'b1, 1'b0);
        step(r_ins(2, 8, 1, 2), 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0);
        n_total++;
        if (Out !== 32'h0000FFF8 || OutValid !== 1'b1)
            $display("FAIL fwd_producer: Out=%h OutValid=%b expected 0000fff8/1", Out, OutValid);
        else n_pass++;
        step(32'h0, 1'b1, 1'b0);
        n_total++;
        if (Out !== want_d1 || OutValid !== 1'b1)
            $display("FAIL fwd_dist1: Out=%h OutValid=%b expected %h/1", Out, OutValid, want_d1);
        else n_pass++;
        // Same dependency with one NOP in between gives the same answer in both builds.
        step(i_ins(0, 2, 0, 16'hFFF8), 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0);
        step(r_ins(2, 9, 1, 2), 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0);
        n_total++;
        if (Out !== 32'h00010002 || OutValid !== 1'b1)
            $display("FAIL fwd_dist2: Out=%h OutValid=%b expected 00010002/1", Out, OutValid);
        else n_pass++;
    endtask

    task automatic test_write_disable;
        step(i_ins(0, 3, 0, 16'h0005), 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        n_total++;
        if (Out !== 32'h00000005 || OutValid !== 1'b1)
            $display("FAIL we_low_retire: Out=%h OutValid=%b expected 00000005/1", Out, OutValid);
        else n_pass++;
        step(r_ins(0, 4, 0, 3), 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0);
        n_total++;
        if (Out !== 32'h00000000 || OutValid !== 1'b1)
            $display("FAIL we_low_unwritten: Out=%h OutValid=%b expected 00000000/1", Out, OutValid);
        else n_pass++;
    endtask

    task automatic test_alu_ops;
        step(r_ins(1, 7, 1, 0), 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0);
        step(r_ins(6, 15, 7, 1), 1'b1, 1'b0);
        n_total++;
        if (Out !== 32'hFFFFFFF5 || OutValid !== 1'b1)
            $display("FAIL alu_not: Out=%h OutValid=%b expected fffffff5/1", Out, OutValid);
        else n_pass++;
        step(r_ins(6, 15, 7, 7), 1'b1, 1'b0);
        step(i_ins(6, 6, 6, 16'hFFF8), 1'b1, 1'b0);
        n_total++;
        if (Out !== 32'h00000001 || OutValid !== 1'b1)
            $display("FAIL alu_slt_neg: Out=%h OutValid=%b expected 00000001/1", Out, OutValid);
        else n_pass++;
        step(32'h0, 1'b1, 1'b0);
        n_total++;
        if (Out !== 32'h00000000 || OutValid !== 1'b1)
            $display("FAIL alu_slt_eq: Out=%h OutValid=%b expected 00000000/1", Out, OutValid);
        else n_pass++;
        step(32'h0, 1'b1, 1'b0);
        n_total++;
        if (Out !== 32'h00000001 || OutValid !== 1'b1)
            $display("FAIL alu_slt_imm: Out=%h OutValid=%b expected 00000001/1", Out, OutValid);
        else n_pass++;
    endtask

    task automatic test_reset_midstream;
        step(i_ins(0, 9, 0, 16'h1234), 1'b1, 1'b0);
        step(i_ins(0, 10, 0, 16'h5678), 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b1);
        n_total++;
        if (Out !== 32'h0 || OutValid !== 1'b0)
            $display("FAIL midrst_out: Out=%h OutValid=%b expected 00000000/0", Out, OutValid);
        else n_pass++;
        step(r_ins(4, 11, 9, 10), 1'b1, 1'b0);
        step(i_ins(2, 1, 1, 16'h0007), 1'b1, 1'b0);
        n_total++;
        if (OutValid !== 1'b0) $display("FAIL midrst_drain: OutValid=%b expected 0", OutValid);
        else n_pass++;
        step(32'h0, 1'b1, 1'b0);
        n_total++;
        if (Out !== 32'h0 || OutValid !== 1'b1)
            $display("FAIL midrst_targets: Out=%h OutValid=%b expected 00000000/1", Out, OutValid);
        else n_pass++;
        step(32'h0, 1'b1, 1'b0);
        n_total++;
        if (Out !== 32'h00000007 || OutValid !== 1'b1)
            $display("FAIL midrst_resume: Out=%h OutValid=%b expected 00000007/1", Out, OutValid);
        else n_pass++;
    endtask

    task automatic test_random_stream;
        logic [31:0] ins;
        logic        we;
        logic        r;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 7))
                0:       ins = $urandom;
                1, 2, 3: ins = r_ins($urandom_range(0, 7), $urandom_range(0, 7),
                                     $urandom_range(0, 7), $urandom_range(0, 7));
                4:       ins = 32'h0;
                default: ins = i_ins($urandom_range(0, 7), $urandom_range(0, 7),
                                     $urandom_range(0, 7), 16'($urandom));
            endcase
            we = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 63) == 0);
            step(ins, we, r);
            n_total++;
            if (OutValid !== exp_valid || (exp_valid && Out !== exp_out))
                $display("FAIL random[%0d]: Out=%h OutValid=%b expected %h/%b",
                         c, Out, OutValid, exp_out, exp_valid);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_add_imm;
        test_forwarding;
        test_write_disable;
        test_alu_ops;
        test_reset_midstream;
        test_random_stream;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
